// File: rtl/vram_controller.sv
// Two-plane video RAM controller.
// Scanout reads take priority; CPU commands (read, write, xor-draw, clear)
// only touch memory in cycles where no scanout plane is reading.
module vram_controller #(
    parameter int ADDR_WIDTH  = 9,
    parameter int PLANE_WIDTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [ADDR_WIDTH-1:0]      vram_address_low,
    input  logic [ADDR_WIDTH-1:0]      vram_address_high,
    input  logic [1:0]                 vram_start,
    output logic [2*PLANE_WIDTH-1:0]   vram_data,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [1:0]                 cmd_planes,
    input  logic [ADDR_WIDTH-1:0]      cmd_address,
    input  logic [2*PLANE_WIDTH-1:0]   cmd_wdata,
    output logic                       resp_valid,
    output logic [2*PLANE_WIDTH-1:0]   resp_rdata,
    output logic                       resp_collision
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int PW    = PLANE_WIDTH;
    localparam int W     = 2 * PLANE_WIDTH;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_XOR   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [2:0] {IDLE, RD, WR, CLR, RESP} state_t;

    // Plane storage; contents come up as the device configuration leaves
    // them (all zero) and are deliberately untouched by reset.
    logic [PW-1:0] mem_low  [DEPTH];
    logic [PW-1:0] mem_high [DEPTH];

    state_t              state;
    logic [1:0]          op_q;
    logic [1:0]          planes_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic [W-1:0]        wdata_q;
    logic [W-1:0]        old_q;

    logic                owned;
    logic [W-1:0]        mask;
    logic [W-1:0]        new_word;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [1:0]          wr_en;

    // The controller may only use the memory when neither plane is scanning out.
    assign owned     = (vram_start == 2'b00);
    assign mask      = {{PW{planes_q[1]}}, {PW{planes_q[0]}}};
    assign cmd_ready = (state == IDLE) && !reset;

    // Write-port selection: word, address and per-plane enables for this cycle.
    always_comb begin
        new_word = '0;
        wr_addr  = addr_q;
        wr_en    = 2'b00;
        case (state)
            WR: begin
                new_word = (op_q == OP_WRITE) ? wdata_q : (old_q ^ wdata_q);
                wr_en    = planes_q & {2{owned}};
            end
            CLR: begin
                wr_addr = clr_cnt;
                wr_en   = planes_q & {2{owned}};
            end
            default: ;
        endcase
        if (reset) wr_en = 2'b00;
    end

    // Memory write port, one enable per plane so unselected planes never change.
    always_ff @(posedge clock) begin
        if (wr_en[0]) mem_low[wr_addr]  <= new_word[PW-1:0];
        if (wr_en[1]) mem_high[wr_addr] <= new_word[W-1:PW];
    end

    // Scanout read: a plane's half updates only when that plane requests, else holds.
    always_ff @(posedge clock) begin
        if (reset) begin
            vram_data <= '0;
        end else begin
            if (vram_start[0]) vram_data[PW-1:0] <= mem_low[vram_address_low];
            if (vram_start[1]) vram_data[W-1:PW] <= mem_high[vram_address_high];
        end
    end

    // Command FSM: memory steps advance only in owned cycles; RESP never stalls.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            op_q           <= '0;
            planes_q       <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            old_q          <= '0;
            clr_cnt        <= '0;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_collision <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q     <= cmd_op;
                        planes_q <= cmd_planes;
                        addr_q   <= cmd_address;
                        wdata_q  <= cmd_wdata;
                        clr_cnt  <= '0;
                        case (cmd_op)
                            OP_READ, OP_XOR: state <= RD;
                            OP_WRITE:        state <= WR;
                            default:         state <= CLR;
                        endcase
                    end
                end
                RD: begin
                    if (owned) begin
                        old_q <= {mem_high[addr_q], mem_low[addr_q]};
                        state <= (op_q == OP_XOR) ? WR : RESP;
                    end
                end
                WR: begin
                    if (owned) state <= RESP;
                end
                CLR: begin
                    if (owned) begin
                        clr_cnt <= clr_cnt + 1'b1;
                        if (&clr_cnt) state <= RESP;
                    end
                end
                RESP: begin
                    resp_valid     <= 1'b1;
                    resp_rdata     <= (op_q == OP_READ || op_q == OP_XOR) ? (old_q & mask) : '0;
                    resp_collision <= (op_q == OP_XOR) && (|(old_q & wdata_q & mask));
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // OP_CLEAR is decoded via the default arm above.
    logic unused_op_clear;
    assign unused_op_clear = (op_q == OP_CLEAR);
endmodule

// File: doc/vram_controller.md
Name: vram_controller

Overview:
- Owns the two-plane video RAM: plane 0 (low) and plane 1 (high), each 512 words x 16 bits, arranged as 64 rows x 8 words per row (128x64 pixels).
- Serves the scanout engine's per-plane read requests, driven by `vram_address_low`, `vram_address_high` and `vram_start`, and returns `vram_data`.
- Executes CPU-side commands on the same memory: read, write, XOR-draw with collision detection, and clear.
- Scanout reads always win; CPU commands stall around them.

Parameters:
- ADDR_WIDTH, 9, word address width per plane (depth = 2**ADDR_WIDTH).
- PLANE_WIDTH, 16, bits per word per plane; `vram_data` and `cmd_wdata` are 2*PLANE_WIDTH wide.

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- vram_address_low  in  9  scanout word address for plane 0.
- vram_address_high  in  9  scanout word address for plane 1.
- vram_start  in  2  per-plane scanout read request (bit 0 = plane 0).
- vram_data  out  32  scanout read data; [15:0] plane 0, [31:16] plane 1.
- cmd_valid  in  1  CPU command valid.
- cmd_ready  out  1  controller idle and able to accept a command.
- cmd_op  in  2  00 read, 01 write, 10 xor, 11 clear.
- cmd_planes  in  2  plane select mask; bit i enables plane i.
- cmd_address  in  9  word address; ignored for clear.
- cmd_wdata  in  32  write/xor data; [15:0] plane 0, [31:16] plane 1.
- resp_valid  out  1  one-cycle command-complete pulse.
- resp_rdata  out  32  old/read data; unselected plane halves forced to 0.
- resp_collision  out  1  xor collision flag; 0 for all other ops.

Behaviour:
- Reset values:
  - state IDLE.
  - `vram_data` = 0, `resp_valid` = 0, `resp_rdata` = 0, `resp_collision` = 0.
  - `cmd_ready` = 0 while reset is high, and 1 on the first cycle after reset if IDLE.
- Memory contents are initialised to 0 at configuration. Reset does NOT clear memory.
- Scanout port:
  - In any cycle where `vram_start[i]` = 1, plane i is read at its address.
  - The `vram_data` half for plane i updates on the next edge, giving 1-cycle latency.
  - When `vram_start[i]` = 0, that half holds its value.
  - The scanout side samples data 2 cycles after raising start; holding is mandatory.
- Ownership:
  - A cycle is "owned" by the controller only when `vram_start` = 2'b00.
  - The FSM performs a memory step only in owned cycles; otherwise it stays in its current state (stall).
- Handshake:
  - A command is accepted on an edge where `cmd_valid` && `cmd_ready`.
  - `cmd_op`, `cmd_planes`, `cmd_address` and `cmd_wdata` are latched on acceptance.
  - `cmd_ready` = 1 only in IDLE.
  - `resp_valid` pulses exactly once per accepted command.
  - `cmd_ready` returns high in the same cycle as `resp_valid`.
- States:
  - IDLE: wait for acceptance, then enter the op state.
  - RD: one owned step reads both planes at the latched address. Next cycle the old data is captured.
    - read: go to RESP with resp_rdata = old & mask.
    - xor: go to WR.
  - WR: one owned step writes the selected planes.
    - write: new = wdata.
    - xor: new = old ^ wdata; resp_collision = |(old & wdata & mask); resp_rdata = old & mask.
    - Then go to RESP.
  - CLR:
    - An internal 9-bit counter starts at 0.
    - Each owned step writes 0 to the selected planes at the counter address, then increments.
    - After address 511 is written, go to RESP. The counter does not wrap into a second pass.
  - RESP: `resp_valid` = 1 for one cycle, then IDLE.
- Latency with no stalls, with acceptance at edge T:
  - read: resp_valid at T+2.
  - write: resp_valid at T+2.
  - xor: resp_valid at T+3.
  - clear: resp_valid at T+513.
  - Each non-owned cycle at a step adds exactly 1 cycle.
- Mask rules:
  - cmd_planes = 00 is legal. No memory change; resp_rdata = 0; collision = 0; latency unchanged.
  - Unselected planes are never written.
- XOR atomicity: no other CPU write occurs between the RD and WR of one command.
- Scanout during a command:
  - A scanout read between RD and WR returns pre-write data.
  - A scanout read after WR returns the new data.
- Reset mid-command:
  - The command is aborted with no resp_valid.
  - Memory keeps any words already written; a partial clear is allowed.
- resp_rdata/resp_collision hold their values until the next RESP.

Test Plan:
1. Reset, then write op=01 planes=11 addr=0x005 wdata=0xBEEF1234; then read addr=0x005 planes=11. Required: resp_rdata = 0xBEEF1234 at T+2, collision = 0.
2. With 0x005 = 0xBEEF1234, xor planes=01 wdata=0x0000FFFF. Required:
   - resp_rdata = 0x00001234, collision = 1 at T+3.
   - Subsequent read planes=11 returns 0xBEEFEDCB.
3. Preload addr 0x1F8 = 0xAAAA5555; drive vram_start=01, vram_address_low=0x1F8, and vram_address_high=0x1F8 at the same time. Required:
   - vram_data[15:0] = 0x5555 next cycle, held after start drops.
   - vram_data[31:16] stays 0 until `vram_start[1]` = 1, then reads 0xAAAA.
4. Issue xor while `vram_start` is held nonzero for 3 cycles across the RD step. Required:
   - resp_valid at T+6.
   - No write occurs in any cycle with `vram_start` != 0.
5. Fill all 512 words with 0xFFFFFFFF, then clear planes=10. Required:
   - resp_valid at T+513.
   - Every word reads 0x0000FFFF.
   - cmd_ready = 0 throughout.
6. Assert reset mid-clear at step 100. Required:
   - No resp_valid.
   - Words 0..99 are cleared and the rest are unchanged.
   - cmd_ready = 1 after reset.
